// File: rtl/ctrl_desplazamiento.sv
// -----------------------------------------------------------------------------
// ctrl_desplazamiento
//
// Multi-cycle shift controller for the RV32I execution stage. Performs SLL,
// SRL and SRA on a 32-bit operand, moving at most PASO bit positions per
// clock, so a narrow shifter can stand in for a full barrel shifter.
//
// Parameters:
//   PASO        max bit positions shifted per cycle (1, 2, 4, 8 or 16)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   inicio      request strobe, accepted only while ocupado=0
//   a[31:0]     operand to shift
//   b[4:0]      shift amount, 0..31
//   izquierda   1 = shift left (SLL), 0 = shift right
//   con_signo   right shifts only: 1 = arithmetic, 0 = logical
//   Y[31:0]     accumulator / result; valid while listo=1
//   listo       one-cycle done pulse
//   ocupado     high in every state except REPOSO
//
// Build option:
//   DES_RAPIDO_EN  when defined, the shift step that exhausts the remaining
//                  count goes straight to FIN, and a b=0 request goes from
//                  REPOSO directly to FIN. Results are unchanged; only the
//                  latency drops.
// -----------------------------------------------------------------------------
module ctrl_desplazamiento #(
  parameter int PASO = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inicio,
  input  logic [31:0] a,
  input  logic [4:0]  b,
  input  logic        izquierda,
  input  logic        con_signo,
  output logic [31:0] Y,
  output logic        listo,
  output logic        ocupado
);

  // Per-cycle shift amount only needs enough bits to encode 0..PASO, which
  // keeps the datapath shifter as narrow as the step size allows.
  localparam int            NW     = $clog2(PASO + 1);
  localparam logic [NW-1:0] PASO_N = NW'(PASO);
  localparam logic [4:0]    PASO_R = 5'(PASO);

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    DESPLAZA = 2'd1,
    FIN      = 2'd2
  } estado_t;

  estado_t     r_estado;
  logic [31:0] r_acum;
  logic [4:0]  r_restante;
  logic        r_izq;
  logic        r_relleno;   // fill bit for right shifts: con_signo & a[31]
  logic        r_listo;
  logic        r_ocupado;

  logic [NW-1:0] w_n;
  logic [31:0]   w_izq;
  logic [31:0]   w_der;
  logic [31:0]   w_desp;

  // Step size for this cycle: min(PASO, restante).
  assign w_n = (r_restante >= PASO_R) ? PASO_N : r_restante[NW-1:0];

  // Left shifts always fill with zero. Right shifts OR in a mask of the
  // vacated top bits when the latched fill bit is set (arithmetic, negative).
  assign w_izq  = r_acum << w_n;
  assign w_der  = (r_acum >> w_n) | (r_relleno ? ~(32'hFFFF_FFFF >> w_n) : 32'h0);
  assign w_desp = r_izq ? w_izq : w_der;

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado   <= REPOSO;
      r_acum     <= '0;
      r_restante <= '0;
      r_izq      <= 1'b0;
      r_relleno  <= 1'b0;
      r_listo    <= 1'b0;
      r_ocupado  <= 1'b0;
    end else begin
      // NOTE: listo defaults low every cycle; only the transition into FIN
      // raises it, which makes it a single-cycle pulse by construction.
      r_listo <= 1'b0;

      case (r_estado)
        REPOSO: begin
          if (inicio) begin
            r_acum     <= a;
            r_restante <= b;
            r_izq      <= izquierda;
            r_relleno  <= ~izquierda & con_signo & a[31];
            r_ocupado  <= 1'b1;
`ifdef DES_RAPIDO_EN
            if (b == 5'd0) begin
              r_estado <= FIN;
              r_listo  <= 1'b1;
            end else begin
              r_estado <= DESPLAZA;
            end
`else
            r_estado   <= DESPLAZA;
`endif
          end
        end

        DESPLAZA: begin
          if (r_restante != 5'd0) begin
            r_acum     <= w_desp;
            r_restante <= r_restante - 5'(w_n);
`ifdef DES_RAPIDO_EN
            // Last step: skip the idle DESPLAZA cycle.
            if (r_restante == 5'(w_n)) begin
              r_estado <= FIN;
              r_listo  <= 1'b1;
            end
`endif
          end else begin
            r_estado <= FIN;
            r_listo  <= 1'b1;
          end
        end

        FIN: begin
          // Y holds; any inicio seen here is ignored.
          r_estado  <= REPOSO;
          r_ocupado <= 1'b0;
        end

        default: begin
          r_estado  <= REPOSO;
          r_ocupado <= 1'b0;
        end
      endcase
    end
  end

  assign Y       = r_acum;
  assign listo   = r_listo;
  assign ocupado = r_ocupado;

endmodule

// File: tb/tb_ctrl_desplazamiento.sv
// -----------------------------------------------------------------------------
// tb_ctrl_desplazamiento
//
// Directed bench for ctrl_desplazamiento. Two instances share the stimulus:
// dut1 with PASO=1 and dut4 with PASO=4. Inputs are driven and outputs are
// sampled on the falling clock edge. Latency is counted in rising edges after
// the accepting edge, at which listo is first seen high.
// -----------------------------------------------------------------------------
module tb_ctrl_desplazamiento;

  logic        clk;
  logic        rst;
  logic        inicio;
  logic [31:0] a;
  logic [4:0]  b;
  logic        izquierda;
  logic        con_signo;

  logic [31:0] y1, y4;
  logic        listo1, listo4;
  logic        ocupado1, ocupado4;

  int n_cmp = 0;
  int n_err = 0;

  ctrl_desplazamiento #(.PASO(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .inicio    (inicio),
    .a         (a),
    .b         (b),
    .izquierda (izquierda),
    .con_signo (con_signo),
    .Y         (y1),
    .listo     (listo1),
    .ocupado   (ocupado1)
  );

  ctrl_desplazamiento #(.PASO(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .inicio    (inicio),
    .a         (a),
    .b         (b),
    .izquierda (izquierda),
    .con_signo (con_signo),
    .Y         (y4),
    .listo     (listo4),
    .ocupado   (ocupado4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request from idle (called at a falling edge), scramble the
  // operands after the accept edge, then watch both instances for 40 cycles.
  task automatic run(input string tag, input logic [31:0] ia, input logic [4:0] ib,
                     input logic iizq, input logic isig, input logic [31:0] exp_y,
                     input int lat1, input int lat4);
    int          got1, got4, pul1, pul4;
    logic [31:0] cap1, cap4;
    got1 = 0; got4 = 0; pul1 = 0; pul4 = 0;
    cap1 = '0; cap4 = '0;
    a = ia; b = ib; izquierda = iizq; con_signo = isig; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0; a = ~ia; b = ~ib; izquierda = ~iizq; con_signo = ~isig;
    check({tag, " ocupado1 after accept"}, {31'b0, ocupado1}, 32'd1);
    check({tag, " ocupado4 after accept"}, {31'b0, ocupado4}, 32'd1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (listo1) begin
        pul1++;
        if (got1 == 0) begin got1 = c; cap1 = y1; end
      end
      if (listo4) begin
        pul4++;
        if (got4 == 0) begin got4 = c; cap4 = y4; end
      end
    end
    check({tag, " Y1"},         cap1,               exp_y);
    check({tag, " lat1"},       32'(got1),          32'(lat1));
    check({tag, " pulses1"},    32'(pul1),          32'd1);
    check({tag, " Y4"},         cap4,               exp_y);
    check({tag, " lat4"},       32'(got4),          32'(lat4));
    check({tag, " pulses4"},    32'(pul4),          32'd1);
    check({tag, " idle1"},      {31'b0, ocupado1},  32'd0);
    check({tag, " hold Y1"},    y1,                 exp_y);
  endtask

  initial begin
    int pul;

    // ---- Reset held two cycles with inicio high ----
    rst = 1'b1; inicio = 1'b1; a = 32'hDEAD_BEEF; b = 5'd5;
    izquierda = 1'b0; con_signo = 1'b0;
    @(negedge clk);
    check("rst c1 Y1",       y1,                32'h0);
    check("rst c1 ocupado1", {31'b0, ocupado1}, 32'd0);
    @(negedge clk);
    check("rst c2 Y1",       y1,                32'h0);
    check("rst c2 listo1",   {31'b0, listo1},   32'd0);
    check("rst c2 ocupado1", {31'b0, ocupado1}, 32'd0);
    check("rst c2 Y4",       y4,                32'h0);
    check("rst c2 ocupado4", {31'b0, ocupado4}, 32'd0);
    rst = 1'b0; inicio = 1'b0;
    @(negedge clk);
    check("post rst no accept ocupado1", {31'b0, ocupado1}, 32'd0);
    check("post rst Y1",                 y1,                32'h0);

    // ---- SRL sweep (lat1 = b+1, lat4 = ceil(b/4)+1) ----
    run("srl b0", 32'h8000_0000, 5'd0, 1'b0, 1'b0, 32'h8000_0000, 1, 1);
    run("srl b1", 32'h8000_0000, 5'd1, 1'b0, 1'b0, 32'h4000_0000, 2, 2);
    run("srl b2", 32'h8000_0000, 5'd2, 1'b0, 1'b0, 32'h2000_0000, 3, 2);
    run("srl b3", 32'h8000_0000, 5'd3, 1'b0, 1'b0, 32'h1000_0000, 4, 2);
    run("srl b4", 32'h8000_0000, 5'd4, 1'b0, 1'b0, 32'h0800_0000, 5, 2);

    // ---- SRA sweep ----
    run("sra b0", 32'h8000_0000, 5'd0, 1'b0, 1'b1, 32'h8000_0000, 1, 1);
    run("sra b1", 32'h8000_0000, 5'd1, 1'b0, 1'b1, 32'hC000_0000, 2, 2);
    run("sra b2", 32'h8000_0000, 5'd2, 1'b0, 1'b1, 32'hE000_0000, 3, 2);
    run("sra b3", 32'h8000_0000, 5'd3, 1'b0, 1'b1, 32'hF000_0000, 4, 2);
    run("sra b4", 32'h8000_0000, 5'd4, 1'b0, 1'b1, 32'hF800_0000, 5, 2);

    // ---- Mixed patterns ----
    run("sra pos",      32'h7000_0000, 5'd3,  1'b0, 1'b1, 32'h0E00_0000, 4,  2);
    run("sll sig ign",  32'h8000_0001, 5'd1,  1'b1, 1'b1, 32'h0000_0002, 2,  2);
    run("srl b6",       32'hF000_0000, 5'd6,  1'b0, 1'b0, 32'h03C0_0000, 7,  3);
    run("sra b31",      32'h8000_0000, 5'd31, 1'b0, 1'b1, 32'hFFFF_FFFF, 32, 9);

    // ---- SLL boundary b=31 ----
    run("sll b31",      32'h0000_0001, 5'd31, 1'b1, 1'b0, 32'h8000_0000, 32, 9);

    // ---- b=0 with inicio asserted during the listo cycle ----
    a = 32'h1234_5678; b = 5'd0; izquierda = 1'b0; con_signo = 1'b0; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    check("busy ocupado1 c0", {31'b0, ocupado1}, 32'd1);
    @(negedge clk);
    check("busy listo1 c1",   {31'b0, listo1},   32'd1);
    check("busy listo4 c1",   {31'b0, listo4},   32'd1);
    check("busy Y1 c1",       y1,                32'h1234_5678);
    a = 32'hFFFF_FFFF; b = 5'd3; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    check("busy ocupado1 c2", {31'b0, ocupado1}, 32'd0);
    check("busy listo1 c2",   {31'b0, listo1},   32'd0);
    check("busy Y1 c2",       y1,                32'h1234_5678);
    check("busy Y4 c2",       y4,                32'h1234_5678);
    @(negedge clk);
    check("busy ocupado1 c3", {31'b0, ocupado1}, 32'd0);
    check("busy Y1 c3",       y1,                32'h1234_5678);

    // ---- Reset mid-operation ----
    a = 32'h8000_0000; b = 5'd20; izquierda = 1'b0; con_signo = 1'b1; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst Y1",       y1,                32'h0);
    check("midrst ocupado1", {31'b0, ocupado1}, 32'd0);
    check("midrst listo1",   {31'b0, listo1},   32'd0);
    check("midrst Y4",       y4,                32'h0);
    check("midrst ocupado4", {31'b0, ocupado4}, 32'd0);
    pul = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (listo1 || listo4) pul++;
    end
    check("midrst no listo", 32'(pul), 32'd0);
    run("after midrst srl", 32'hF000_0000, 5'd4, 1'b0, 1'b0, 32'h0F00_0000, 5, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_desplazamiento.md
Name: ctrl_desplazamiento

Overview:
Multi-cycle shift unit controller for the RV32I execution stage. It sequences SLL, SRL and SRA operations on a 32-bit operand, shifting by at most PASO positions per clock. This lets a small shifter replace the single-cycle barrel shifter where area matters. The ALU issues a request with a start pulse and waits for a one-cycle done pulse.

Parameters:
PASO, 1, maximum bit positions shifted per cycle; legal values 1, 2, 4, 8, 16.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
inicio  input  1  request strobe; accepted only when ocupado=0
a  input  32  operand to shift
b  input  5  shift amount, 0..31
izquierda  input  1  1 = shift left (SLL), 0 = shift right
con_signo  input  1  right shifts only: 1 = arithmetic (fill with a[31]), 0 = logical; ignored when izquierda=1
Y  output  32  result register; valid while listo=1; holds until the next accepted request
listo  output  1  one-cycle done pulse
ocupado  output  1  high in every state except REPOSO

Behaviour:
- Reset: when rst=1 at a rising edge, the state becomes REPOSO, Y=0, listo=0, ocupado=0, and the internal counters clear. This applies mid-operation: the in-flight request is discarded and no listo is produced.
- States: REPOSO, DESPLAZA, FIN.
- REPOSO: if inicio=1, then capture a into the accumulator (Y), capture b into restante, and latch izquierda, con_signo and the fill bit a[31]. Go to DESPLAZA. Otherwise hold.
- DESPLAZA, restante!=0: shift the accumulator by n = min(PASO, restante) in the latched direction, then restante -= n.
  - Left shifts fill with 0.
  - Right-logical shifts fill with 0.
  - Right-arithmetic shifts fill with the latched a[31].
- DESPLAZA, restante==0: go to FIN.
- FIN: listo=1 for exactly this cycle, then go to REPOSO. Y is unchanged.
- Latency: let k = ceil(b/PASO). listo is high in the (k+1)th cycle after the accept edge. For b=0, listo is high in the cycle immediately after accept.
- inicio while ocupado=1, including in FIN, is ignored. No queueing, and captured operands are not disturbed.
- a, b, izquierda and con_signo may change after the accept edge without effect.
- Y is the accumulator, so it shows intermediate values during DESPLAZA. Consumers sample Y only when listo=1.
- Result must equal the combinational reference: (a << b), (a >> b), or ($signed(a) >>> b).
- ocupado rises the cycle after accept and falls the cycle after listo.

Optional Feature:
Macro: DES_RAPIDO_EN.
- Defined:
  - The shift step that brings restante to 0 transitions directly to FIN.
  - An accept with b=0 goes straight from REPOSO to FIN.
  - Latency becomes max(k,1) cycles after accept; the idle DESPLAZA cycle is removed.
- Undefined: behaviour exactly as described above.
- Results are identical in both builds; only latency differs.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with inicio=1 → Y=0x00000000, listo=0, ocupado=0, and no accept occurs.
2. SRL, PASO=1: a=0x80000000, b=4, izquierda=0, con_signo=0 → Y=0x08000000, listo high 5 cycles after accept (4 with DES_RAPIDO_EN). Sweep b=0..4 → Y=0x80000000, 0x40000000, 0x20000000, 0x10000000, 0x08000000.
3. SRA, PASO=1: a=0x80000000, b=0..4, con_signo=1 → Y=0x80000000, 0xC0000000, 0xE0000000, 0xF0000000, 0xF8000000.
4. SLL, boundary: a=0x00000001, b=31, izquierda=1.
   - PASO=1 → Y=0x80000000, listo at cycle 32 after accept.
   - PASO=4 → same Y, listo at cycle 9.
5. b=0 and busy-ignore: a=0x12345678, b=0 → Y=0x12345678, listo one cycle after accept. A second inicio with a=0xFFFFFFFF, asserted in the cycle listo=1, is ignored; Y stays 0x12345678 and ocupado falls next cycle.
6. Reset mid-operation: start SRA a=0x80000000, b=20; assert rst for one cycle 3 cycles after accept → Y=0, ocupado=0, listo never pulses. A new request a=0xF0000000, b=4, SRL then yields Y=0x0F000000.
